// File: rtl/prng_stream.sv
// prng_stream: Galois-LFSR pseudo-random word source with a valid/ready
// output stream, runtime seed load and STEPS LFSR shifts per emitted word.
//
// Optional build macro: PRNG_WHITEN_EN
//   defined   -> rnd captures lfsr ^ (lfsr >> (WIDTH/2)) (whitening fold)
//   undefined -> rnd captures the raw LFSR value
// The LFSR sequence, timing and handshake are the same in both builds.
//
// Output handshake: rnd/out_valid are registered. While out_valid is high,
// rnd and out_valid do not change (except on seed_we or reset). A word
// transfers on every rising clk edge where out_valid && out_ready. A seed load
// in the same cycle as such an edge still counts as a completed transfer.
//
// Parameter legality (not checked in hardware):
//   WIDTH 4..32, STEPS 1..WIDTH, TAPS maximal-length for WIDTH.

module prng_stream #(
  parameter int          WIDTH = 32,
  parameter logic [31:0] TAPS  = 32'hA3000000,
  parameter logic [31:0] SEED  = 32'd1,
  parameter int          STEPS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             seed_we,
  input  logic [WIDTH-1:0] seed_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rnd
);

  // Counter only has to reach STEPS-1, and STEPS is at most WIDTH.
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(STEPS - 1);
  localparam logic [WIDTH-1:0] TAP_MASK  = TAPS[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] SEED_W    = SEED[WIDTH-1:0];
  // A zero seed would lock the LFSR at zero forever.
  localparam logic [WIDTH-1:0] SEED_INIT = (SEED_W == '0) ? ONE_W : SEED_W;

  typedef enum logic {
    ST_FILL    = 1'b0,
    ST_PRESENT = 1'b1
  } state_e;

  // One Galois shift: feed back the tap mask when the bit shifted out is 1.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = v >> 1;
    if (v[0]) begin
      r = r ^ TAP_MASK;
    end
    return r;
  endfunction

  // Word that is presented on rnd for a given LFSR value.
  function automatic logic [WIDTH-1:0] out_word(input logic [WIDTH-1:0] v);
`ifdef PRNG_WHITEN_EN
    return v ^ (v >> (WIDTH / 2));
`else
    return v;
`endif
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rnd_q, rnd_d;
  logic             valid_q, valid_d;

  logic [WIDTH-1:0] lfsr_next;
  logic [WIDTH-1:0] seed_safe;
  logic             xfer;

  // Shared combinational helpers: next LFSR value, guarded seed, handshake.
  always_comb begin
    lfsr_next = lfsr_step(lfsr_q);
    seed_safe = (seed_in == '0) ? ONE_W : seed_in;
    xfer      = valid_q && out_ready;
  end

  // Next-state logic: seed load overrides everything, then FILL/PRESENT.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    rnd_d   = rnd_q;
    valid_d = valid_q;

    if (seed_we) begin
      // Aborts any fill in progress; a same-cycle transfer already happened
      // on this edge from the consumer's point of view.
      lfsr_d  = seed_safe;
      cnt_d   = '0;
      valid_d = 1'b0;
      state_d = ST_FILL;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (en) begin
            lfsr_d = lfsr_next;
            if (cnt_q == LAST_CNT) begin
              rnd_d   = out_word(lfsr_next);
              valid_d = 1'b1;
              cnt_d   = '0;
              state_d = ST_PRESENT;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_PRESENT: begin
          // Word held regardless of en; LFSR does not move in the
          // handshake cycle.
          if (xfer) begin
            valid_d = 1'b0;
            state_d = ST_FILL;
          end
        end
        default: begin
          state_d = ST_FILL;
          valid_d = 1'b0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_FILL;
      lfsr_q  <= SEED_INIT;
      cnt_q   <= '0;
      rnd_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      rnd_q   <= rnd_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q;
  assign rnd       = rnd_q;

endmodule
